// File: rtl/uart_alu_ctrl_if.sv
// Bundle of the RX FIFO read port, TX FIFO write port and ALU operand/result wires
// seen by the UART/ALU sequencer. The master modport is the sequencer side.
interface uart_alu_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned OP_WIDTH   = 6
);
  logic                  i_rx_empty;
  logic [DATA_WIDTH-1:0] i_rx_data;
  logic                  o_rx_read;
  logic                  i_tx_full;
  logic                  o_tx_write;
  logic [DATA_WIDTH-1:0] o_tx_data;
  logic [DATA_WIDTH-1:0] o_alu_a;
  logic [DATA_WIDTH-1:0] o_alu_b;
  logic [OP_WIDTH-1:0]   o_alu_op;
  logic [DATA_WIDTH-1:0] i_alu_result;
  logic                  o_done;
  logic [DATA_WIDTH-1:0] o_count;

  modport master (
    input  i_rx_empty, i_rx_data, i_tx_full, i_alu_result,
    output o_rx_read, o_tx_write, o_tx_data, o_alu_a, o_alu_b, o_alu_op, o_done, o_count
  );

  modport slave (
    output i_rx_empty, i_rx_data, i_tx_full, i_alu_result,
    input  o_rx_read, o_tx_write, o_tx_data, o_alu_a, o_alu_b, o_alu_op, o_done, o_count
  );
endinterface

// File: rtl/uart_alu_ctrl.sv
// Sequencer: pops A, B and opcode from the RX FIFO, runs them through the external ALU and
// pushes the result to the TX FIFO, never reading an empty or writing a full FIFO.
module uart_alu_ctrl #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned OP_WIDTH   = 6
) (
  input  logic              i_clock,
  input  logic              i_reset,
  uart_alu_ctrl_if.master   bus
);

  typedef enum logic [2:0] {
    StReqA, StWaitA, StReqB, StWaitB, StReqOp, StWaitOp, StExec, StPush
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] alu_a_q, alu_a_d;
  logic [DATA_WIDTH-1:0] alu_b_q, alu_b_d;
  logic [OP_WIDTH-1:0]   alu_op_q, alu_op_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic [DATA_WIDTH-1:0] count_q, count_d;
  logic                  rx_read;
  logic                  tx_write;

  always_comb begin
    state_d   = state_q;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    alu_op_d  = alu_op_q;
    tx_data_d = tx_data_q;
    count_d   = count_q;
    rx_read   = 1'b0;
    tx_write  = 1'b0;
    unique case (state_q)
      StReqA: begin
        if (!bus.i_rx_empty) begin
          rx_read = 1'b1;
          state_d = StWaitA;
        end
      end
      StWaitA: begin
        alu_a_d = bus.i_rx_data;
        state_d = StReqB;
      end
      StReqB: begin
        if (!bus.i_rx_empty) begin
          rx_read = 1'b1;
          state_d = StWaitB;
        end
      end
      StWaitB: begin
        alu_b_d = bus.i_rx_data;
        state_d = StReqOp;
      end
      StReqOp: begin
        if (!bus.i_rx_empty) begin
          rx_read = 1'b1;
          state_d = StWaitOp;
        end
      end
      StWaitOp: begin
        // Upper opcode byte bits are dropped; the ALU only decodes OP_WIDTH bits.
        alu_op_d = bus.i_rx_data[OP_WIDTH-1:0];
        state_d  = StExec;
      end
      StExec: begin
        tx_data_d = bus.i_alu_result;
        state_d   = StPush;
      end
      StPush: begin
        if (!bus.i_tx_full) begin
          tx_write = 1'b1;
          count_d  = count_q + DATA_WIDTH'(1);
          state_d  = StReqA;
        end
      end
      default: state_d = StReqA;
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= StReqA;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_op_q  <= '0;
      tx_data_q <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      alu_op_q  <= alu_op_d;
      tx_data_q <= tx_data_d;
      count_q   <= count_d;
    end
  end

  // Reset state is StReqA, so a non-empty RX FIFO would otherwise pop while reset is held.
  assign bus.o_rx_read  = rx_read & ~i_reset;
  assign bus.o_tx_write = tx_write & ~i_reset;
  assign bus.o_done     = tx_write & ~i_reset;
  assign bus.o_tx_data  = tx_data_q;
  assign bus.o_alu_a    = alu_a_q;
  assign bus.o_alu_b    = alu_b_q;
  assign bus.o_alu_op   = alu_op_q;
  assign bus.o_count    = count_q;

endmodule

// File: tb/tb_uart_alu_ctrl.sv
// Randomized bench for uart_alu_ctrl: queue-based RX/TX FIFO models and a byte-stream
// reference that turns every three bytes written to RX into one expected TX result.
module tb_uart_alu_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_alu_ctrl_if #(.DATA_WIDTH(8), .OP_WIDTH(6)) bus ();

  uart_alu_ctrl #(.DATA_WIDTH(8), .OP_WIDTH(6)) dut (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  function automatic logic [7:0] alu_f(logic [7:0] a, logic [7:0] b, logic [5:0] op);
    case (op)
      6'h20:   return a + b;
      6'h22:   return a - b;
      6'h24:   return a & b;
      6'h25:   return a | b;
      6'h26:   return a ^ b;
      6'h27:   return ~(a | b);
      default: return a ^ b ^ {2'b00, op};
    endcase
  endfunction

  always_comb bus.i_alu_result = alu_f(bus.o_alu_a, bus.o_alu_b, bus.o_alu_op);

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] asm_b[3];
  int         asm_n = 0;
  int         cyc = 0;
  int         pushes = 0;
  int         rd_cnt = 0;
  bit         last_rd, last_wr;
  int         rd_log[$];
  int         wr_log[$];

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Every third byte closes a transaction: A, B, then opcode.
  task automatic send_byte(logic [7:0] b);
    rx_q.push_back(b);
    asm_b[asm_n] = b;
    asm_n++;
    if (asm_n == 3) begin
      exp_q.push_back(alu_f(asm_b[0], asm_b[1], asm_b[2][5:0]));
      asm_n = 0;
    end
  endtask

  task automatic send_txn(logic [7:0] a, logic [7:0] b, logic [7:0] op);
    send_byte(a);
    send_byte(b);
    send_byte(op);
  endtask

  function automatic int rd_at(int i);
    return (rd_log.size() > i) ? rd_log[i] : -1000;
  endfunction

  function automatic int wr_at(int i);
    return (wr_log.size() > i) ? wr_log[i] : -1000;
  endfunction

  // One clock cycle, entered and left at the falling edge.
  task automatic step();
    logic rd, wr;
    logic [7:0] e;
    bus.i_rx_empty = (rx_q.size() == 0);
    #1;
    rd = bus.o_rx_read;
    wr = bus.o_tx_write;
    check("rd_while_empty", rd & bus.i_rx_empty, 0);
    check("wr_while_full", wr & bus.i_tx_full, 0);
    check("done_vs_write", bus.o_done, wr);
    last_rd = rd;
    last_wr = wr;
    if (rd) begin
      rd_cnt++;
      rd_log.push_back(cyc);
    end
    if (wr) begin
      pushes++;
      wr_log.push_back(cyc);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("tx_data", bus.o_tx_data, e);
      end else begin
        check("unexpected_push", 1, 0);
      end
    end
    @(posedge clk);
    if (rd && rx_q.size() > 0) bus.i_rx_data = rx_q.pop_front();
    #1;
    if (wr) check("count", bus.o_count, pushes % 256);
    cyc++;
    @(negedge clk);
  endtask

  task automatic wait_pushes(int target, int budget);
    int n = 0;
    while (pushes < target && n < budget) begin
      step();
      n++;
    end
    check("push_timeout", pushes >= target, 1);
  endtask

  task automatic wait_reads(int target, int budget);
    int n = 0;
    while (rd_cnt < target && n < budget) begin
      step();
      n++;
    end
    check("read_timeout", rd_cnt >= target, 1);
  endtask

  task automatic check_all_zero(string pfx);
    check({pfx, "_rd"}, bus.o_rx_read, 0);
    check({pfx, "_wr"}, bus.o_tx_write, 0);
    check({pfx, "_done"}, bus.o_done, 0);
    check({pfx, "_txd"}, bus.o_tx_data, 0);
    check({pfx, "_a"}, bus.o_alu_a, 0);
    check({pfx, "_b"}, bus.o_alu_b, 0);
    check({pfx, "_op"}, bus.o_alu_op, 0);
    check({pfx, "_cnt"}, bus.o_count, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] ops[6];
    logic [7:0] a, b, op;
    int base, n;
    ops = '{8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h27};
    bus.i_rx_empty = 1'b1;
    bus.i_rx_data  = '0;
    bus.i_tx_full  = 1'b0;

    // Reset with data waiting: no pop may happen while reset is high.
    send_txn(8'h05, 8'h03, 8'h20);
    bus.i_rx_empty = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);

    // Happy path and best-case timing.
    rst = 1'b0;
    base = cyc;
    rd_log.delete();
    wr_log.delete();
    wait_pushes(1, 40);
    check("happy_pop0", rd_at(0), base);
    check("happy_pop1", rd_at(1), base + 2);
    check("happy_pop2", rd_at(2), base + 4);
    check("happy_push", wr_at(0), base + 7);
    check("happy_a", bus.o_alu_a, 8'h05);
    check("happy_b", bus.o_alu_b, 8'h03);
    check("happy_op", bus.o_alu_op, 8'h20);
    check("happy_res", bus.o_tx_data, 8'h08);
    check("happy_cnt", bus.o_count, 1);

    // Starvation in REQ_OP.
    send_byte(8'hF0);
    send_byte(8'h0F);
    wait_reads(rd_cnt + 2, 20);
    repeat (10) begin
      step();
      check("starve_no_rd", last_rd, 0);
    end
    send_byte(8'h24);
    rd_log.delete();
    wr_log.delete();
    wait_pushes(pushes + 1, 20);
    check("starve_latency", wr_at(0) - rd_at(0), 3);
    check("starve_res", bus.o_tx_data, 8'h00);

    // Asynchronous reset in WAIT_B.
    send_byte(8'h5A);
    send_byte(8'h3C);
    wait_reads(rd_cnt + 2, 20);
    #2 rst = 1'b1;
    #1;
    check_all_zero("midrst");
    @(posedge clk);
    @(negedge clk);
    rx_q.delete();
    exp_q.delete();
    asm_n  = 0;
    pushes = 0;
    rst    = 1'b0;
    send_txn(8'h11, 8'h22, 8'h20);
    base = cyc;
    rd_log.delete();
    wr_log.delete();
    wait_pushes(1, 40);
    check("midrst_a", bus.o_alu_a, 8'h11);
    check("midrst_b", bus.o_alu_b, 8'h22);
    check("midrst_res", bus.o_tx_data, 8'h33);
    check("midrst_push", wr_at(0), base + 7);

    // Counter wrap on the 256th push, back to back with random operands.
    for (int i = 1; i < 256; i++) begin
      a  = 8'($urandom);
      b  = 8'($urandom);
      op = ($urandom_range(0, 3) == 0) ? 8'($urandom) : ops[$urandom_range(0, 5)];
      send_txn(a, b, op);
    end
    wr_log.delete();
    wait_pushes(256, 4000);
    check("wrap_cnt", bus.o_count, 0);
    check("wrap_gap", wr_at(254) - wr_at(253), 8);

    // Backpressure: TX full for 5 cycles on entry to PUSH.
    bus.i_tx_full = 1'b1;
    send_txn(8'h33, 8'h44, 8'h25);
    wait_reads(rd_cnt + 3, 20);
    step();
    step();
    repeat (5) begin
      check("bp_data", bus.o_tx_data, 8'h77);
      step();
      check("bp_no_wr", last_wr, 0);
      check("bp_no_rd", last_rd, 0);
    end
    bus.i_tx_full = 1'b0;
    step();
    check("bp_release", last_wr, 1);

    // Opcode truncation then a back-to-back transaction.
    send_txn(8'hFF, 8'h01, 8'hE2);
    send_txn(8'h10, 8'h10, 8'h20);
    wr_log.delete();
    wait_pushes(pushes + 1, 20);
    check("trunc_op", bus.o_alu_op, 8'h22);
    check("trunc_res", bus.o_tx_data, 8'hFE);
    wait_pushes(pushes + 1, 20);
    check("b2b_res", bus.o_tx_data, 8'h20);
    check("b2b_gap", wr_at(1) - wr_at(0), 8);

    // Random traffic with random TX backpressure.
    for (int i = 0; i < 30; i++) begin
      send_txn(8'($urandom), 8'($urandom), ops[$urandom_range(0, 5)] | 8'($urandom_range(0, 3) << 6));
    end
    base = pushes + 30;
    n = 0;
    while (pushes < base && n < 1000) begin
      bus.i_tx_full = ($urandom_range(0, 2) == 0);
      step();
      n++;
    end
    bus.i_tx_full = 1'b0;
    check("rand_done", pushes, base);
    check("exp_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_alu_ctrl.md
# uart_alu_ctrl

Sequencer between the UART receive FIFO, the ALU and the UART transmit FIFO. It pops three bytes from the RX FIFO (operand A, operand B, opcode), presents them to the combinational ALU, and pushes the result into the TX FIFO. It is the only master of the RX FIFO read port and the TX FIFO write port, and it never reads an empty FIFO or writes a full one.

## Interface

Parameters:
- DATA_WIDTH, 8, operand, result and FIFO word width
- OP_WIDTH, 6, ALU opcode width; must be ≤ DATA_WIDTH

Ports:
- i_clock  in  1  system clock; all state changes on its rising edge
- i_reset  in  1  asynchronous, active-high reset
- i_rx_empty  in  1  RX FIFO empty flag
- i_rx_data  in  DATA_WIDTH  RX FIFO read data; valid the cycle after o_rx_read
- o_rx_read  out  1  RX FIFO pop strobe, one-cycle pulse
- i_tx_full  in  1  TX FIFO full flag
- o_tx_write  out  1  TX FIFO push strobe, one-cycle pulse
- o_tx_data  out  DATA_WIDTH  result word to TX FIFO, registered
- o_alu_a  out  DATA_WIDTH  operand A, registered
- o_alu_b  out  DATA_WIDTH  operand B, registered
- o_alu_op  out  OP_WIDTH  opcode, registered; i_rx_data[OP_WIDTH-1:0]
- i_alu_result  in  DATA_WIDTH  combinational ALU result
- o_done  out  1  one-cycle pulse in the cycle the result is pushed
- o_count  out  DATA_WIDTH  number of results pushed since reset; wraps modulo 2^DATA_WIDTH

## Operation

- FSM states: REQ_A, WAIT_A, REQ_B, WAIT_B, REQ_OP, WAIT_OP, EXEC, PUSH. Reset state is REQ_A.
- REQ_x (x = A, B, OP):
  - If i_rx_empty = 0: assert o_rx_read for this cycle and go to WAIT_x.
  - Otherwise: stay in REQ_x with o_rx_read = 0.
- WAIT_x:
  - Latch i_rx_data into o_alu_a, o_alu_b, or o_alu_op (low OP_WIDTH bits; upper bits discarded).
  - Go to the next REQ state, or from WAIT_OP to EXEC.
  - o_rx_read is 0 in this state.
- EXEC: latch i_alu_result into o_tx_data; go to PUSH.
- PUSH:
  - If i_tx_full = 0: assert o_tx_write and o_done, increment o_count, go to REQ_A.
  - Otherwise: hold in PUSH with o_tx_write = 0. o_tx_data stays stable.
- o_alu_a, o_alu_b and o_alu_op hold their values until overwritten by the next transaction, so the ALU inputs are stable through EXEC.
- o_rx_read and o_tx_write are combinational decodes of state and flags, never asserted together. At most one RX pop is outstanding.
- Asserting i_reset at any time:
  - Discards partially collected operands.
  - Forces REQ_A.
  - Zeros all registers.
  - No strobe is emitted while reset is high.

## Timing

- Reset values: o_rx_read = 0, o_tx_write = 0, o_done = 0, o_tx_data = 0, o_alu_a = 0, o_alu_b = 0, o_alu_op = 0, o_count = 0.
- Best case (RX never empty, TX never full):
  - Pops at cycles 0, 2 and 4 after leaving reset.
  - EXEC at cycle 6; push pulse at cycle 7.
  - Throughput is one result per 8 cycles.
- Each RX-empty cycle in a REQ state adds one cycle. Each TX-full cycle in PUSH adds one cycle.
- o_rx_read is sampled by the FIFO at the same edge that moves the FSM to WAIT_x. i_rx_data is sampled at the following edge.
- o_tx_data is valid from the edge leaving EXEC until after the o_tx_write edge.
- o_count increments at the edge ending the PUSH cycle in which o_tx_write = 1. It wraps from 0xFF to 0x00 for DATA_WIDTH = 8.
- If the RX FIFO becomes non-empty in the same cycle the FSM enters REQ_x, the pop occurs in that cycle; there is no extra delay.

## Test plan

- Happy path: preload RX with 0x05, 0x03, 0x20; bench ALU model implements ADD for 0x20. Required: o_alu_a = 0x05, o_alu_b = 0x03, o_alu_op = 0x20; o_tx_data = 0x08 with o_tx_write high exactly 7 cycles after the first o_rx_read; o_count = 1.
- Starvation: push 0xF0 and 0x0F, then leave RX empty for 10 cycles, then push 0x24 (AND). Required: FSM holds in REQ_OP with o_rx_read = 0 throughout the gap; result 0x00 pushed 3 cycles after the opcode arrives.
- Backpressure: hold i_tx_full = 1 for 5 cycles when entering PUSH. Required: o_tx_write = 0 and o_tx_data stable during the hold; one pulse the cycle after full drops; no RX pop during the hold.
- Mid-operation reset: assert i_reset asynchronously in WAIT_B. Required: all outputs immediately 0; after release, next three bytes are treated as A, B, OP (not as B, OP, A).
- Opcode truncation and back-to-back: send 0xFF, 0x01, 0xE2 (low 6 bits 0x22 = SUB), then a second transaction 0x10, 0x10, 0x20. Required: o_alu_op = 0x22, results 0xFE then 0x20, o_done pulses 8 cycles apart.
- Counter wrap: run 256 back-to-back transactions. Required: o_count returns to 0x00 on the 256th push.
